// File: rtl/alu_result_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, default line parameters and the
// clocks-per-tick divider calculation, reused by the TX side and the planned RX.
package alu_result_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DEF_N_TICKS = 16;
    localparam int DEF_BAUD    = 9600;

    function automatic int uart_div(input int clk_freq, input int baud, input int n_ticks);
        return clk_freq / (baud * n_ticks);
    endfunction

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Handshake bundle between the ALU result loader (master) and the UART
// transmitter (slave), including the serial line and status outputs.
interface alu_result_uart_tx_if #(
    parameter int NB_DATA = 8
);
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx;
    logic               o_tx_busy;
    logic               o_tx_done;

    modport master (
        output i_tx_start,
        output i_data,
        input  o_tx,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_tx_start,
        input  i_data,
        output o_tx,
        output o_tx_busy,
        output o_tx_done
    );
endinterface

// File: rtl/alu_result_uart_tx_baud_rate_gen.sv
// Free-running baud tick generator: one tick every DIV clocks, restartable by a
// synchronous clear so a new frame always begins on a full tick period.
module baud_rate_gen
    import alu_result_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = DEF_BAUD,
    parameter int N_TICKS  = DEF_N_TICKS
) (
    input  logic i_clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DIV   = uart_div(CLK_FREQ, BAUD, N_TICKS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 1) begin : g_div_check
            $error("baud_rate_gen: CLK_FREQ too low for BAUD*N_TICKS (DIV < 1)");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign o_tick = (div_q == DIV_W'(DIV - 1));

    always_comb begin
        div_d = div_q + 1'b1;
        if (i_clr || o_tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// UART transmitter for ALU results: sends one NB_DATA-bit word per accepted
// start request as start bit, LSB-first data bits and one stop bit.
module alu_result_uart_tx
    import alu_result_uart_tx_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = DEF_BAUD,
    parameter int N_TICKS  = DEF_N_TICKS
) (
    input  logic                 i_clk,
    input  logic                 rst,
    alu_result_uart_tx_if.slave  bus
);

    localparam int TICK_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam int BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    uart_state_e        state_q, state_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baud_clr;
    logic               tick;
    logic               last_tick;

    baud_rate_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .N_TICKS  (N_TICKS)
    ) u_baud (
        .i_clk  (i_clk),
        .rst    (rst),
        .i_clr  (baud_clr),
        .o_tick (tick)
    );

    assign last_tick = tick && (tick_cnt_q == TICK_W'(N_TICKS - 1));

    // Line level is computed one cycle ahead so o_tx leaves a flop glitch-free.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        baud_clr   = 1'b0;

        if (tick && !last_tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.i_tx_start) begin
                    shreg_d    = bus.i_data;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    baud_clr   = 1'b1;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    tx_d       = shreg_q[0];
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    shreg_d    = shreg_q >> 1;
                    if (bit_idx_q == BIT_W'(NB_DATA - 1)) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shreg_d[0];
                    end
                end
            end
            ST_STOP: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    tx_d       = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = busy_q;
    assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Self-checking bench for alu_result_uart_tx: a scoreboard queue of expected
// line frames is filled by the driver and checked bit by bit by a line monitor.
module tb_alu_result_uart_tx;

    localparam int NB         = 8;
    localparam int CF         = 64;
    localparam int BD         = 1;
    localparam int NT         = 16;
    localparam int BIT_CLKS   = 64;
    localparam int FRAME_CLKS = 640;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic clock = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;
    int   done_cnt = 0;
    int   frames_seen = 0;
    int   last_done_cycle = 0;
    int   last_start_cycle = 0;
    bit   mon_en = 1'b1;
    logic [9:0] exp_q[$];
    vec_t vecs[5];

    always #5 clock = ~clock;

    alu_result_uart_tx_if #(.NB_DATA(NB)) bus ();

    alu_result_uart_tx #(
        .NB_DATA  (NB),
        .CLK_FREQ (CF),
        .BAUD     (BD),
        .N_TICKS  (NT)
    ) dut (
        .i_clk (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always @(posedge clock) cycle_cnt++;
    always @(negedge clock) if (bus.o_tx_done === 1'b1) done_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [9:0] frame);
        @(negedge clock);
        bus.i_data     = data;
        bus.i_tx_start = 1'b1;
        exp_q.push_back(frame);
        @(negedge clock);
        bus.i_tx_start = 1'b0;
    endtask

    task automatic waitFrames(input int target, input string name);
        int n = 0;
        while (frames_seen < target && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, 32'(frames_seen >= target), 32'd1);
    endtask

    // Line monitor: every frame is checked on all of its clocks, bit by bit.
    initial begin
        logic [9:0] fr;
        bit         bit_ok;
        forever begin
            @(negedge clock);
            if (mon_en && bus.o_tx_busy === 1'b1) begin
                last_start_cycle = cycle_cnt;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                    fr = 10'h3ff;
                end else begin
                    fr = exp_q.pop_front();
                end
                for (int b = 0; b < 10; b++) begin
                    bit_ok = 1'b1;
                    for (int c = 0; c < BIT_CLKS; c++) begin
                        if (b > 0 || c > 0) @(negedge clock);
                        if (bus.o_tx !== fr[b] || bus.o_tx_busy !== 1'b1 || bus.o_tx_done !== 1'b0)
                            bit_ok = 1'b0;
                    end
                    checkOutput($sformatf("frame%0d_bit%0d_ok", frames_seen, b), 32'(bit_ok), 32'd1);
                end
                @(negedge clock);
                checkOutput($sformatf("frame%0d_done", frames_seen), 32'(bus.o_tx_done), 32'd1);
                checkOutput($sformatf("frame%0d_busy_end", frames_seen), 32'(bus.o_tx_busy), 32'd0);
                last_done_cycle = cycle_cnt;
                frames_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int dc;
        int done1;
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h5A, 10'b1_01011010_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};

        rst            = 1'b1;
        bus.i_tx_start = 1'b0;
        bus.i_data     = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("reset_tx", 32'(bus.o_tx), 32'd1);
        checkOutput("reset_busy", 32'(bus.o_tx_busy), 32'd0);
        checkOutput("reset_done", 32'(bus.o_tx_done), 32'd0);
        repeat (20) @(negedge clock);
        checkOutput("idle_tx", 32'(bus.o_tx), 32'd1);
        checkOutput("idle_busy", 32'(bus.o_tx_busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            dc   = done_cnt;
            base = frames_seen;
            applyStimulus(vecs[i].data, vecs[i].frame);
            waitFrames(base + 1, $sformatf("vec%0d_frame_seen", i));
            @(negedge clock);
            checkOutput($sformatf("vec%0d_done_count", i), 32'(done_cnt - dc), 32'd1);
        end

        // Start requests and data changes while busy must not disturb the frame.
        dc   = done_cnt;
        base = frames_seen;
        applyStimulus(8'hA5, 10'b1_10100101_0);
        repeat (100) @(negedge clock);
        bus.i_data     = 8'hFF;
        bus.i_tx_start = 1'b1;
        @(negedge clock);
        bus.i_tx_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            bus.i_data = ~bus.i_data;
        end
        bus.i_tx_start = 1'b1;
        @(negedge clock);
        bus.i_tx_start = 1'b0;
        waitFrames(base + 1, "ignore_frame_seen");
        repeat (10) @(negedge clock);
        checkOutput("ignore_done_count", 32'(done_cnt - dc), 32'd1);
        checkOutput("ignore_idle_busy", 32'(bus.o_tx_busy), 32'd0);

        // Held start: second frame is accepted in the done cycle of the first.
        base = frames_seen;
        @(negedge clock);
        bus.i_data     = 8'h01;
        bus.i_tx_start = 1'b1;
        exp_q.push_back(10'b1_00000001_0);
        exp_q.push_back(10'b1_10000000_0);
        @(negedge clock);
        bus.i_data = 8'h80;
        waitFrames(base + 1, "b2b_first_seen");
        done1 = last_done_cycle;
        for (int n = 0; n < 10 && bus.o_tx_busy !== 1'b1; n++) @(negedge clock);
        bus.i_tx_start = 1'b0;
        waitFrames(base + 2, "b2b_second_seen");
        checkOutput("b2b_start_gap", 32'(last_start_cycle - done1), 32'd1);
        checkOutput("b2b_done_spacing", 32'(last_done_cycle - done1), 32'(FRAME_CLKS + 1));

        // Reset during data bit 3 aborts the frame without a done pulse.
        mon_en = 1'b0;
        @(negedge clock);
        bus.i_data     = 8'hA5;
        bus.i_tx_start = 1'b1;
        @(negedge clock);
        bus.i_tx_start = 1'b0;
        repeat (4 * BIT_CLKS + 30) @(negedge clock);
        checkOutput("abort_pre_busy", 32'(bus.o_tx_busy), 32'd1);
        checkOutput("abort_pre_tx_bit3", 32'(bus.o_tx), 32'd0);
        dc  = done_cnt;
        rst = 1'b1;
        @(negedge clock);
        checkOutput("abort_tx", 32'(bus.o_tx), 32'd1);
        checkOutput("abort_busy", 32'(bus.o_tx_busy), 32'd0);
        checkOutput("abort_done", 32'(bus.o_tx_done), 32'd0);
        rst = 1'b0;
        repeat (FRAME_CLKS + 20) @(negedge clock);
        checkOutput("abort_no_done", 32'(done_cnt - dc), 32'd0);
        checkOutput("abort_stay_idle", 32'(bus.o_tx_busy), 32'd0);
        mon_en = 1'b1;
        base   = frames_seen;
        applyStimulus(8'h3C, 10'b1_00111100_0);
        waitFrames(base + 1, "post_abort_frame_seen");

        // A start request in a reset cycle is never accepted.
        @(negedge clock);
        rst            = 1'b1;
        bus.i_data     = 8'h55;
        bus.i_tx_start = 1'b1;
        @(negedge clock);
        rst            = 1'b0;
        bus.i_tx_start = 1'b0;
        checkOutput("rst_start_tx", 32'(bus.o_tx), 32'd1);
        checkOutput("rst_start_busy", 32'(bus.o_tx_busy), 32'd0);
        repeat (5) @(negedge clock);
        checkOutput("rst_start_tx_later", 32'(bus.o_tx), 32'd1);
        checkOutput("rst_start_busy_later", 32'(bus.o_tx_busy), 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
